cv32e40p_ft_selftest_ctrl: RTL and testbench

Periodic self-test scheduler for the triplicated compressed-decoder group. While the decode stage is idle, it replaces the replicas' input with a pseudo-random stream of test instructions and counts per-replica disagreements reported by the voters. At the end of each run it pulses `set_broken` for a single clearly faulty replica, so the breakage monitors retire it before it corrupts live traffic.

---
 rtl/cv32e40p_ft_selftest_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cv32e40p_ft_selftest_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40p_ft_selftest_ctrl
//
// Periodic self-test scheduler for the triplicated compressed-decoder group.
// While the decode stage is idle it steers a pseudo-random stream of
// compressed-format test instructions onto all three replicas and counts the
// per-replica disagreements reported by the voters. At the end of a complete
// run a single clearly faulty replica is reported through set_broken_o so the
// breakage monitors retire it. If two or more replicas look faulty in the same
// run, nothing is retired and multi_fail_o is raised instead.
//
// Optional feature macro: CV32E40P_FT_SELFTEST_PERIODIC_EN
//   defined   : an interval counter starts a run every INTERVAL WAIT cycles.
//   undefined : runs start only on start_i; INTERVAL is unused.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_i       in   request an immediate run (honoured in WAIT only)
//   idle_i        in   decode-stage input unused this cycle
//   block_err_i   in   [2:0] per-replica disagreement from the voters
//   test_sel_o    out  steer test_instr_o onto the replica inputs (comb.)
//   test_instr_o  out  [31:0] current test instruction (comb.)
//   set_broken_o  out  [2:0] one-cycle retire pulse (registered)
//   busy_o        out  high in ARMED and TEST (registered)
//   done_o        out  one-cycle pulse in REPORT (registered)
//   fail_o        out  [2:0] sticky per-replica fault flags (registered)
//   multi_fail_o  out  sticky: one run flagged >= 2 replicas (registered)
// ---------------------------------------------------------------------------
module cv32e40p_ft_selftest_ctrl #(
    parameter int unsigned INTERVAL       = 1024,
    parameter int unsigned NUM_VECTORS    = 16,
    parameter int unsigned FAIL_THRESHOLD = 2,
    parameter logic [31:0] LFSR_SEED      = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        idle_i,
    input  logic [2:0]  block_err_i,
    output logic        test_sel_o,
    output logic [31:0] test_instr_o,
    output logic [2:0]  set_broken_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  fail_o,
    output logic        multi_fail_o
);

    localparam logic [31:0]  LFSR_TAPS = 32'h8020_0003;
    localparam int unsigned  CW        = $clog2(NUM_VECTORS + 1);
    localparam logic [CW-1:0] VEC_LAST = CW'(NUM_VECTORS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_VECTORS);
    localparam logic [CW-1:0] THRESH   = CW'(FAIL_THRESHOLD);

    // Elaboration-time guard against unusable parameter sets.
    if ((INTERVAL < 2) || (NUM_VECTORS < 1) || (FAIL_THRESHOLD < 1) ||
        (FAIL_THRESHOLD > NUM_VECTORS) || (LFSR_SEED == 32'h0000_0000)) begin : g_bad_params
        $error("cv32e40p_ft_selftest_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ARMED  = 2'd1,
        S_TEST   = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = {1'b0, v[31:1]};
        if (v[0]) begin
            r = r ^ LFSR_TAPS;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Saturating mismatch-counter increment.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic hit);
        logic [CW-1:0] r;
        if (hit && (c != CNT_MAX)) begin
            r = c + CW'(1);
        end else begin
            r = c;
        end
        return r;
    endfunction

    // Number of set bits in a 3-bit vector.
    function automatic logic [1:0] ones3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    state_e                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [CW-1:0]          vec_q, vec_d;
    logic [2:0][CW-1:0]     cnt_q, cnt_d, cnt_inc_s;
    logic [2:0]             flag_s;
    logic [2:0]             set_broken_q, set_broken_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [2:0]             fail_q, fail_d;
    logic                   multi_q, multi_d;
    logic                   test_sel_s;
    logic                   arm_s;
    logic                   expire_s;

    assign test_sel_s   = (state_q == S_TEST) && idle_i;
    assign test_sel_o   = test_sel_s;
    // Never emit 2'b11 in the low bits so every vector is compressed-format.
    assign test_instr_o = {lfsr_q[31:2], (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0]};
    assign set_broken_o = set_broken_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign fail_o       = fail_q;
    assign multi_fail_o = multi_q;

`ifdef CV32E40P_FT_SELFTEST_PERIODIC_EN
    localparam int unsigned   IW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0] INT_LOAD = IW'(INTERVAL - 1);

    logic [IW-1:0] int_q, int_d;

    assign expire_s = (state_q == S_WAIT) && (int_q == {IW{1'b0}});

    // Interval counter: counts down only in WAIT, reloads whenever a run is armed.
    always_comb begin
        int_d = int_q;
        if (arm_s) begin
            int_d = INT_LOAD;
        end else if ((state_q == S_WAIT) && (int_q != {IW{1'b0}})) begin
            int_d = int_q - IW'(1);
        end else begin
            int_d = int_q;
        end
    end

    // Interval counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_q <= INT_LOAD;
        end else begin
            int_q <= int_d;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Mismatch counts including this cycle's voter result, and the fault flags
    // they imply; used both to update the counters and to judge the last vector.
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            cnt_inc_s[m] = sat_inc(cnt_q[m], block_err_i[m] & test_sel_s);
            flag_s[m]    = (cnt_inc_s[m] >= THRESH);
        end
    end

    // Next-state logic, run bookkeeping and registered-output inputs.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        set_broken_d = 3'b000;
        done_d       = 1'b0;
        fail_d       = fail_q;
        multi_d      = multi_q;
        arm_s        = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (start_i || expire_s) begin
                    state_d = S_ARMED;
                    arm_s   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ARMED: begin
                if (idle_i) begin
                    state_d = S_TEST;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_TEST: begin
                if (!idle_i) begin
                    // Live traffic arrived: discard the partial run and re-arm.
                    state_d = S_ARMED;
                    arm_s   = 1'b1;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    vec_d  = vec_q + CW'(1);
                    cnt_d  = cnt_inc_s;
                    if (vec_q == VEC_LAST) begin
                        // Verdict is registered so it is visible during REPORT.
                        state_d = S_REPORT;
                        done_d  = 1'b1;
                        if (ones3(flag_s) == 2'd1) begin
                            set_broken_d = flag_s;
                            fail_d       = fail_q | flag_s;
                        end else if (ones3(flag_s) >= 2'd2) begin
                            fail_d  = fail_q | flag_s;
                            multi_d = 1'b1;
                        end else begin
                            fail_d = fail_q;
                        end
                    end else begin
                        state_d = S_TEST;
                    end
                end
            end
            S_REPORT: begin
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        if (arm_s) begin
            lfsr_d = LFSR_SEED;
            vec_d  = {CW{1'b0}};
            cnt_d  = {3*CW{1'b0}};
        end else begin
            lfsr_d = lfsr_d;
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_TEST);
    end

    // State, LFSR, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            lfsr_q       <= LFSR_SEED;
            vec_q        <= {CW{1'b0}};
            cnt_q        <= {3*CW{1'b0}};
            set_broken_q <= 3'b000;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            fail_q       <= 3'b000;
            multi_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            set_broken_q <= set_broken_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            fail_q       <= fail_d;
            multi_q      <= multi_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_ft_selftest_ctrl.sv
// Self-checking bench for cv32e40p_ft_selftest_ctrl: a driver issues runs and
// pushes expected results; a monitor pops and compares whenever the DUT shows
// a test vector (test_sel_o) or a run completion (done_o).
module tb_cv32e40p_ft_selftest_ctrl;

    localparam int          NV   = 16;
    localparam int          TH   = 2;
    localparam int          IV   = 1024;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        idle_i;
    logic [2:0]  block_err_i;
    logic        test_sel_o;
    logic [31:0] test_instr_o;
    logic [2:0]  set_broken_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  fail_o;
    logic        multi_fail_o;

    cv32e40p_ft_selftest_ctrl #(
        .INTERVAL(IV), .NUM_VECTORS(NV), .FAIL_THRESHOLD(TH), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .idle_i(idle_i),
        .block_err_i(block_err_i), .test_sel_o(test_sel_o),
        .test_instr_o(test_instr_o), .set_broken_o(set_broken_o),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .multi_fail_o(multi_fail_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] sb;
        logic [2:0] fl;
        logic       mf;
    } res_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          dones_seen = 0;
    int          sel_seen   = 0;
    int          exp_dones  = 0;
    int          last_report = 0;
    res_t        rq[$];
    logic [31:0] iq[$];
    logic [2:0]  err_pat [NV];
    logic [2:0]  exp_fail  = 3'b000;
    logic        exp_multi = 1'b0;
    res_t        mon_r;
    logic [31:0] mon_i;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR: divide by x in GF(2) modulo the tap polynomial.
    function automatic logic [31:0] model_next(input logic [31:0] v);
        if (v % 2 == 1) return (v >> 1) ^ 32'h8020_0003;
        else            return v >> 1;
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] v);
        if ((v & 32'd3) == 32'd3) return v & ~32'd3;
        else                      return v;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (test_sel_o) begin
                sel_seen++;
                if (iq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_vector: got %h expected none (cycle %0d)", test_instr_o, cyc);
                end else begin
                    mon_i = iq.pop_front();
                    check("test_instr", test_instr_o, mon_i);
                end
            end
            if (done_o) begin
                dones_seen++;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    mon_r = rq.pop_front();
                    check("done_cycle", cyc, mon_r.cyc);
                    check("set_broken", set_broken_o, mon_r.sb);
                    check("fail", fail_o, mon_r.fl);
                    check("multi_fail", multi_fail_o, mon_r.mf);
                end
            end else begin
                check("set_broken_quiet", set_broken_o, 3'b000);
            end
        end
    end

    // Push the expected vectors of one full attempt and its verdict.
    task automatic apply_vectors(input int n, input bit full);
        logic [31:0] lf;
        int          cnt [3];
        logic [2:0]  flg;
        int          nflg;
        res_t        r;
        lf = SEED;
        for (int m = 0; m < 3; m++) cnt[m] = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            iq.push_back(model_instr(lf));
            lf = model_next(lf);
            block_err_i = err_pat[k];
            for (int m = 0; m < 3; m++) cnt[m] += err_pat[k][m];
            if (k == 0) check("busy_test", busy_o, 1'b1);
            if (full && k == NV - 1) begin
                flg  = 3'b000;
                nflg = 0;
                for (int m = 0; m < 3; m++) begin
                    if (cnt[m] >= TH) begin flg[m] = 1'b1; nflg++; end
                end
                r.sb = (nflg == 1) ? flg : 3'b000;
                if (nflg >= 1) exp_fail = exp_fail | flg;
                if (nflg >= 2) exp_multi = 1'b1;
                r.fl  = exp_fail;
                r.mf  = exp_multi;
                r.cyc = cyc + 1;
                rq.push_back(r);
                exp_dones++;
            end
        end
    endtask

    task automatic do_run(input int abort_at);
        @(posedge clk); #1;
        start_i = 1'b1; idle_i = 1'b1; block_err_i = 3'b000;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_armed", busy_o, 1'b1);
        if (abort_at >= 0) begin
            apply_vectors(abort_at, 1'b0);
            @(posedge clk); #1;
            idle_i = 1'b0; block_err_i = 3'b000;
            @(negedge clk);
            check("abort_sel", test_sel_o, 1'b0);
            @(posedge clk); #1;
            idle_i = 1'b1;
            check("abort_busy", busy_o, 1'b1);
        end
        apply_vectors(NV, 1'b1);
        @(posedge clk); #1;
        block_err_i = 3'b000;
        last_report = cyc;
        check("busy_report", busy_o, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic clear_pat();
        for (int k = 0; k < NV; k++) err_pat[k] = 3'b000;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; idle_i = 1'b0; block_err_i = 3'b000;
        #1;
        check("rst_test_sel", test_sel_o, 1'b0);
        check("rst_set_broken", set_broken_o, 3'b000);
        check("rst_done", done_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_fail", fail_o, 3'b000);
        check("rst_multi", multi_fail_o, 1'b0);
        check("rst_instr", test_instr_o, SEED);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Clean run.
        clear_pat();
        do_run(-1);
        // Single fault on replica 1.
        clear_pat(); err_pat[3] = 3'b010; err_pat[11] = 3'b010;
        do_run(-1);
        // Multi fault; last vector counts too.
        clear_pat(); err_pat[0] = 3'b011; err_pat[7] = 3'b011; err_pat[15] = 3'b011;
        do_run(-1);
        // Abort at vector 5; errors before the abort must be forgotten.
        clear_pat(); err_pat[2] = 3'b101; err_pat[14] = 3'b100;
        do_run(5);

        // Reset in the middle of a faulty run.
        clear_pat();
        for (int k = 0; k < NV; k++) err_pat[k] = 3'b001;
        @(posedge clk); #1; start_i = 1'b1; idle_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        apply_vectors(10, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; block_err_i = 3'b001;
        #1;
        check("mid_rst_test_sel", test_sel_o, 1'b0);
        check("mid_rst_set_broken", set_broken_o, 3'b000);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_fail", fail_o, 3'b000);
        check("mid_rst_multi", multi_fail_o, 1'b0);
        exp_fail = 3'b000; exp_multi = 1'b0;
        @(posedge clk); #1; rst = 1'b0; block_err_i = 3'b000;
        repeat (NV + 4) @(posedge clk);
        #1;
        check("mid_rst_no_done", dones_seen, exp_dones);

        // Threshold boundary: one mismatch is not enough, two are.
        clear_pat(); err_pat[9] = 3'b001;
        do_run(-1);
        clear_pat(); err_pat[1] = 3'b001; err_pat[9] = 3'b001;
        do_run(-1);

        // Randomised runs with occasional aborts.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NV; k++) begin
                for (int m = 0; m < 3; m++)
                    err_pat[k][m] = ($urandom_range(0, 9) == 0);
            end
            do_run(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NV - 1)) : -1);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

`ifdef CV32E40P_FT_SELFTEST_PERIODIC_EN
        begin
            res_t        r;
            logic [31:0] lf;
            int          budget;
            idle_i = 1'b1; block_err_i = 3'b000;
            for (int p = 1; p <= 2; p++) begin
                lf = SEED;
                for (int k = 0; k < NV; k++) begin
                    iq.push_back(model_instr(lf));
                    lf = model_next(lf);
                end
                r.cyc = last_report + p * (IV + NV + 2);
                r.sb  = 3'b000; r.fl = exp_fail; r.mf = exp_multi;
                rq.push_back(r);
                exp_dones++;
            end
            budget = 0;
            while (dones_seen != exp_dones && budget < 2 * (IV + NV + 2) + 50) begin
                @(posedge clk); budget++;
            end
            #1;
            check("periodic_runs", dones_seen, exp_dones);
        end
`else
        begin
            int sel_before;
            int done_before;
            sel_before  = sel_seen;
            done_before = dones_seen;
            idle_i = 1'b1; block_err_i = 3'b000;
            repeat (IV + 100) @(posedge clk);
            #1;
            check("no_auto_sel", sel_seen, sel_before);
            check("no_auto_done", dones_seen, done_before);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("dones_total", dones_seen, exp_dones);
        check("instr_queue_empty", iq.size(), 0);
        check("result_queue_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
